// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: shared types, sizes and index-to-pattern mapping (PATTERN_GRAY_EN selects Gray encoding)
package pattern_gen_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PAT_COUNT = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;
  function automatic logic [IDX_W-1:0] idx_to_pat(input logic [IDX_W-1:0] idx);
`ifdef PATTERN_GRAY_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction
endpackage

// File: rtl/four_pattern_gen_if.sv
// four_pattern_gen_if: control, pattern and result signals between generator and its environment
interface four_pattern_gen_if;
  import pattern_gen_pkg::*;
  logic start;
  logic loop;
  logic resIn;
  logic outA;
  logic outB;
  logic outC;
  logic outD;
  logic [IDX_W-1:0] patIdx;
  logic busy;
  logic done;
  logic [CNT_W-1:0] hitCount;
  modport master(input start, loop, resIn, output outA, outB, outC, outD, patIdx, busy, done, hitCount);
  modport slave(output start, loop, resIn, input outA, outB, outC, outD, patIdx, busy, done, hitCount);
endinterface

// File: rtl/four_pattern_gen_hold_timer.sv
// hold_timer: counts 0..HOLD-1 while run is high, tick marks the last cycle of each hold
module hold_timer #(parameter int HOLD = 4) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = run && cnt == 8'(HOLD - 1);
  // hold counter, parked at 0 whenever not running
  always_ff @(posedge clk) begin
    if (rst || !run) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 8'd1;
  end
endmodule

// File: rtl/four_pattern_gen.sv
// four_pattern_gen: sweeps 16 four-bit patterns and counts downstream 1 results (PATTERN_GRAY_EN selects Gray order)
module four_pattern_gen import pattern_gen_pkg::*; #(parameter int HOLD = 4) (
  input logic clk,
  input logic rst,
  four_pattern_gen_if.master bus
);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx, pat;
  logic [CNT_W-1:0] acc, acc_nx, hit;
  logic tick, last, done;
  hold_timer #(.HOLD(HOLD)) u_timer (.clk(clk), .rst(rst), .run(state == RUN), .tick(tick));
  assign last = tick && idx == IDX_W'(PAT_COUNT - 1);
  // next state, pattern index and accumulator
  always_comb begin
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) : (last && !bus.loop ? IDLE : RUN);
    idx_nx = state == IDLE ? '0 : idx + IDX_W'(tick);
    acc_nx = state == IDLE || last ? '0 : acc + CNT_W'(tick && bus.resIn);
  end
  // registered state and outputs; pattern is precomputed from the next index so it is a flop output
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      pat <= '0;
      done <= 1'b0;
      hit <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      acc <= acc_nx;
      pat <= state_nx == RUN ? idx_to_pat(idx_nx) : '0;
      done <= last;
      if (last) hit <= acc + CNT_W'(bus.resIn);
    end
  end
  assign {bus.outA, bus.outB, bus.outC, bus.outD} = pat;
  assign bus.patIdx = idx;
  assign bus.busy = state == RUN;
  assign bus.done = done;
  assign bus.hitCount = hit;
endmodule

// File: tb/tb_four_pattern_gen.sv
// tb_four_pattern_gen: directed table-driven bench for four_pattern_gen with HOLD=4 and HOLD=1 instances
module tb_four_pattern_gen;
  typedef struct {
    int n;
    logic [3:0] idx;
    logic [3:0] pat;
    logic busy;
    logic done;
    logic [4:0] hit;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic res1;
  int total = 0;
  int bad = 0;
  logic [3:0] idx_at[201];
  logic [3:0] pat_at[201];
  logic busy_at[201];
  logic done_at[201];
  logic [4:0] hit_at[201];
  vec_t tbl[9];
  four_pattern_gen_if b4();
  four_pattern_gen_if b1();
  four_pattern_gen #(.HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.master));
  four_pattern_gen #(.HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
  assign b4.resIn = b4.outA & b4.outB & b4.outC & b4.outD;
  assign b1.resIn = res1;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // pulse start on the HOLD=4 instance and record outputs for ncyc edges after the sampling edge
  task automatic cap4(input int ncyc, input int restart_n, input int loopoff_n);
    @(posedge clk); #1;
    b4.start = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      if (n == 1) b4.start = 1'b0;
      if (n == restart_n) b4.start = 1'b1;
      if (n == restart_n + 1) b4.start = 1'b0;
      if (n == loopoff_n) b4.loop = 1'b0;
      idx_at[n] = b4.patIdx;
      pat_at[n] = {b4.outA, b4.outB, b4.outC, b4.outD};
      busy_at[n] = b4.busy;
      done_at[n] = b4.done;
      hit_at[n] = b4.hitCount;
    end
  endtask

  // run the HOLD=1 instance until done (bounded) and return the edge count
  task automatic run1(output int dn);
    dn = -1;
    b1.start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        b1.start = 1'b0;
        chk("h1_busy_first", b1.busy, 1);
        chk("h1_idx_first", b1.patIdx, 0);
      end
      if (b1.done) begin
        dn = n;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] p1, p5, p10, p15;
    int dn, cnt;
`ifdef PATTERN_GRAY_EN
    p1 = 4'b0001; p5 = 4'b0111; p10 = 4'b1111; p15 = 4'b1000;
`else
    p1 = 4'b0001; p5 = 4'b0101; p10 = 4'b1010; p15 = 4'b1111;
`endif
    tbl[0] = '{1, 4'd0, 4'd0, 1'b1, 1'b0, 5'd0};
    tbl[1] = '{4, 4'd0, 4'd0, 1'b1, 1'b0, 5'd0};
    tbl[2] = '{5, 4'd1, p1, 1'b1, 1'b0, 5'd0};
    tbl[3] = '{21, 4'd5, p5, 1'b1, 1'b0, 5'd0};
    tbl[4] = '{24, 4'd5, p5, 1'b1, 1'b0, 5'd0};
    tbl[5] = '{41, 4'd10, p10, 1'b1, 1'b0, 5'd0};
    tbl[6] = '{64, 4'd15, p15, 1'b1, 1'b0, 5'd0};
    tbl[7] = '{65, 4'd0, 4'd0, 1'b0, 1'b1, 5'd1};
    tbl[8] = '{66, 4'd0, 4'd0, 1'b0, 1'b0, 5'd1};
    b4.start = 1'b0; b4.loop = 1'b0;
    b1.start = 1'b0; b1.loop = 1'b0;
    res1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pat", {b4.outA, b4.outB, b4.outC, b4.outD}, 0);
    chk("rst_idx", b4.patIdx, 0);
    chk("rst_busy", b4.busy, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_hit", b4.hitCount, 0);
    chk("rst_busy1", b1.busy, 0);
    rst = 1'b0;
    cap4(70, 0, 0);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tbl%0d_idx", i), idx_at[tbl[i].n], tbl[i].idx);
      chk($sformatf("tbl%0d_pat", i), pat_at[tbl[i].n], tbl[i].pat);
      chk($sformatf("tbl%0d_busy", i), busy_at[tbl[i].n], tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), done_at[tbl[i].n], tbl[i].done);
      chk($sformatf("tbl%0d_hit", i), hit_at[tbl[i].n], tbl[i].hit);
    end
    for (int n = 1; n <= 64; n++) chk("idx_trace", idx_at[n], (n - 1) / 4);
`ifdef PATTERN_GRAY_EN
    for (int i = 1; i < 16; i++) chk("gray_step", $countones(pat_at[1 + 4 * i] ^ pat_at[4 * i - 3]), 1);
`else
    for (int i = 0; i < 16; i++) chk("bin_pat", pat_at[1 + 4 * i], i);
`endif
    cnt = 0;
    for (int n = 1; n <= 70; n++) cnt += int'(done_at[n]);
    chk("single_done", cnt, 1);
    @(posedge clk); #1;
    run1(dn);
    chk("h1_done_edge", dn, 17);
    chk("h1_hit16", b1.hitCount, 16);
    chk("h1_busy_end", b1.busy, 0);
    res1 = 1'b0;
    run1(dn);
    chk("h1_done_edge2", dn, 17);
    chk("h1_hit0", b1.hitCount, 0);
    b4.loop = 1'b1;
    cap4(200, 0, 130);
    cnt = 0;
    for (int n = 1; n <= 200; n++) cnt += int'(done_at[n]);
    chk("loop_done_cnt", cnt, 3);
    chk("loop_done1", done_at[65], 1);
    chk("loop_done2", done_at[129], 1);
    chk("loop_done3", done_at[193], 1);
    chk("loop_idx15", idx_at[128], 15);
    chk("loop_wrap_idx", idx_at[129], 0);
    chk("loop_wrap_busy", busy_at[129], 1);
    chk("loop_wrap_busy1", busy_at[65], 1);
    chk("loop_hit", hit_at[129], 1);
    chk("loop_stop_busy", busy_at[193], 0);
    chk("loop_stop_hit", hit_at[193], 1);
    cap4(70, 10, 0);
    chk("restart_busy64", busy_at[64], 1);
    chk("restart_done65", done_at[65], 1);
    chk("restart_busy65", busy_at[65], 0);
    cnt = 0;
    for (int n = 1; n <= 70; n++) cnt += int'(done_at[n]);
    chk("restart_done_cnt", cnt, 1);
    @(posedge clk); #1;
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    for (int n = 0; n < 60 && b4.patIdx != 4'd9; n++) begin
      @(posedge clk); #1;
    end
    chk("reach_idx9", b4.patIdx, 9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_pat", {b4.outA, b4.outB, b4.outC, b4.outD}, 0);
    chk("mid_rst_idx", b4.patIdx, 0);
    chk("mid_rst_busy", b4.busy, 0);
    chk("mid_rst_hit", b4.hitCount, 0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      cnt += int'(b4.done) + int'(b4.busy);
      @(posedge clk); #1;
    end
    chk("mid_rst_quiet", cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/four_pattern_gen.md
# four_pattern_gen

Synchronous stimulus source that sits directly upstream of the 4-input AND stage. It sweeps all 16 combinations of its four outputs, holding each pattern for a programmable number of clocks. It samples the downstream stage's result at the end of each hold and counts how many patterns produced a 1. One start pulse runs one sweep; `loop` makes it repeat continuously.

## Interface
- `HOLD`, default 4: clocks each pattern is held; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `loop` in 1: sampled at the end of each sweep; 1 = restart immediately.
- `resIn` in 1: result returned by the downstream stage.
- `outA`, `outB`, `outC`, `outD` out 1 each: pattern bits; `outA` = bit 3 (MSB), `outD` = bit 0.
- `patIdx` out 4: index of the pattern currently driven.
- `busy` out 1: high while a sweep is running.
- `done` out 1: one-cycle pulse at the end of each sweep.
- `hitCount` out 5: number of 1 samples in the last completed sweep (0..16).

## Operation
- Reset values: all outputs 0; state IDLE; hold counter 0; accumulator 0.
- FSM states: IDLE and RUN.
- IDLE:
  - pattern outputs are 0; `busy` = 0.
  - On `start` = 1: go to RUN; `patIdx` ← 0; hold counter ← 0; accumulator ← 0.
- RUN:
  - Hold counter counts 0..HOLD-1.
  - When the counter reaches HOLD-1: accumulator += `resIn`; counter ← 0; `patIdx` ← `patIdx` + 1 (4-bit, wraps 15→0).
- End of sweep (final sample, when `patIdx` = 15 and counter = HOLD-1):
  - `hitCount` ← accumulator + `resIn`; `done` = 1 for the next cycle.
  - If `loop` = 1: stay in RUN at index 0 and clear the accumulator.
  - If `loop` = 0: go to IDLE; outputs return to 0.
- `start` while in RUN is ignored. `start` in the same cycle `done` is high (IDLE) is accepted.
- `hitCount` holds its value until the next sweep completes or reset. It is not cleared at start.
- HOLD = 1: every cycle is a sample cycle.
- Accumulator is 5 bits; 16 hits is legal and does not overflow.
- `rst` mid-sweep: at the next edge everything returns to reset values and no `done` is produced. `rst` has priority over `start`.

## Timing
- All outputs are registered; no combinational path from input to output.
- `start` sampled at edge k → `busy` = 1 and pattern 0 driven from edge k+1.
- Pattern i is driven during edges k+1+i·HOLD … k+(i+1)·HOLD.
- `resIn` is sampled on the last clock of each hold. The downstream stage gets HOLD-1 cycles of settling margin.
- `done` and `hitCount` update at edge k+1+16·HOLD. Sweep length is 16·HOLD clocks.
- With `loop` = 1, there is no idle cycle between sweeps.

## Configuration
- `PATTERN_GRAY_EN` defined: driven pattern = `patIdx` ^ (`patIdx` >> 1), so exactly one output toggles per step.
- `PATTERN_GRAY_EN` not defined: driven pattern = `patIdx` (binary count, `outD` fastest).
- `patIdx`, sweep timing and counting are identical in both builds.

## Structure
- Package `pattern_gen_pkg` holds:
  - state enum (IDLE, RUN);
  - `PAT_COUNT` = 16, `IDX_W` = 4, `CNT_W` = 5;
  - an index-to-pattern function covering both encodings.
- Sub-module `hold_timer`, parameterised by HOLD:
  - inputs `clk`, `rst`, `run`;
  - output `tick`, high on the last cycle of each hold;
  - the counter clears whenever `run` = 0.

## Test plan
- Reset, binary, HOLD=4, downstream AND: pulse `start` → patterns 0..15, each held 4 clocks; `done` pulses once at 65 clocks after the start edge; `hitCount` = 1; `busy` falls with `done`.
- Pattern check, binary: at index 5, outputs A,B,C,D = 0,1,0,1. With `PATTERN_GRAY_EN` defined: index 5 → 0,1,1,1; successive patterns differ in exactly one bit.
- `resIn` tied 1, HOLD=1: `hitCount` = 16, `done` at 17 clocks; then tie `resIn` to 0 and run again → `hitCount` = 0.
- `loop` = 1 for 3 sweeps: `done` pulses exactly every 16·HOLD clocks; index 0 follows index 15 with no gap; clearing `loop` stops after the current sweep.
- Assert `rst` at index 9 → all outputs 0 the next cycle; no `done`. `start` while busy → sweep length unchanged.
